// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and binary32 constants for the iterative FP pack back end
package fp_pkg;

    localparam int EXP_W_B32 = 8;
    localparam int MAN_W_B32 = 23;

    localparam logic [31:0] QNAN_B32   = 32'h7FC0_0000;
    localparam logic [30:0] INF_B32    = 31'h7F80_0000;
    localparam logic [30:0] MAXFIN_B32 = 31'h7F7F_FFFF;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rmode_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_QNAN = 2'b01,
        SP_INF  = 2'b10
    } special_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp_round_decide.sv
// rtl/fp_round_decide.sv - round-increment and inexact decision from mode, sign, lsb, guard, sticky
module fp_round_decide
    import fp_pkg::*;
(
    input  logic [2:0] rmode_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       guard_i,
    input  logic       sticky_i,
    output logic       inc_o,
    output logic       inexact_o
);

    always_comb begin
        inexact_o = guard_i | sticky_i;
        // Unassigned codes fall through to round-to-nearest-even.
        case (rmode_i)
            RM_RTZ:  inc_o = 1'b0;
            RM_RDN:  inc_o = sign_i & (guard_i | sticky_i);
            RM_RUP:  inc_o = !sign_i & (guard_i | sticky_i);
            RM_RMM:  inc_o = guard_i;
            default: inc_o = guard_i & (sticky_i | lsb_i);
        endcase
    end

endmodule

// File: rtl/fp_pack_iter.sv
// rtl/fp_pack_iter.sv - iterative normalize/round/pack to IEEE word; FP_PACK_FTZ_EN flushes subnormal results
module fp_pack_iter
    import fp_pkg::*;
#(
    parameter int EXP_W      = EXP_W_B32,
    parameter int MAN_W      = MAN_W_B32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+3:0]       in_mant,
    input  logic [2:0]             in_rmode,
    input  logic [1:0]             in_special,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_overflow,
    output logic                   out_underflow,
    output logic                   out_inexact
);

    localparam int  W      = 1 + EXP_W + MAN_W;
    localparam int  MW     = MAN_W + 4;
    localparam int  XW     = EXP_W + 2;
    localparam bit  IS_B32 = (EXP_W == EXP_W_B32) && (MAN_W == MAN_W_B32);

    localparam logic [XW-1:0] EXP_ONE = XW'(1);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    localparam logic [W-1:0] QNAN_W = IS_B32 ? W'(QNAN_B32) :
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0] INF_MAG = IS_B32 ? (W-1)'(INF_B32) :
        {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-2:0] MAXFIN_MAG = IS_B32 ? (W-1)'(MAXFIN_B32) :
        {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    state_e          state_q, state_d;
    logic            sign_q, sign_d;
    logic [2:0]      rmode_q, rmode_d;
    logic [XW-1:0]   exp_q, exp_d;
    logic [MW-1:0]   mant_q, mant_d;
    logic [W-1:0]    res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            inx_q, inx_d;

    logic [2:0]      lz;
    logic            lz_found;
    logic [XW-1:0]   exp_m1;
    logic [XW-1:0]   shift_k;
    logic            rnd_inc;
    logic            rnd_inexact;
    logic [MAN_W+1:0] rnd_sum;
    logic [XW-1:0]   exp_fin;
    logic [MAN_W-1:0] frac_fin;
    logic            pre_tiny;
    logic            rnd_ovf;
    logic            to_max;

    fp_round_decide u_round_decide (
        .rmode_i   (rmode_q),
        .sign_i    (sign_q),
        .lsb_i     (mant_q[2]),
        .guard_i   (mant_q[1]),
        .sticky_i  (mant_q[0]),
        .inc_o     (rnd_inc),
        .inexact_o (rnd_inexact)
    );

    // Leading zeros below the carry position, capped at SHIFT_STEP.
    always_comb begin
        lz       = 3'd0;
        lz_found = 1'b0;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (!lz_found) begin
                if (mant_q[MW-2-i]) lz_found = 1'b1;
                else                lz = lz + 3'd1;
            end
        end
        exp_m1  = exp_q - EXP_ONE;
        shift_k = ({{(XW-3){1'b0}}, lz} > exp_m1) ? exp_m1 : {{(XW-3){1'b0}}, lz};
    end

    always_comb begin
        rnd_sum  = {1'b0, mant_q[MW-2:2]} + {{(MAN_W+1){1'b0}}, rnd_inc};
        // Carry out of the significand bumps the exponent; a subnormal rounding
        // into the hidden bit lands on field 1 because exp_q is already 1 there.
        exp_fin  = rnd_sum[MAN_W+1] ? exp_q + EXP_ONE : (rnd_sum[MAN_W] ? exp_q : '0);
        frac_fin = rnd_sum[MAN_W+1] ? '0 : rnd_sum[MAN_W-1:0];
        pre_tiny = !mant_q[MW-2];
        rnd_ovf  = (exp_fin >= EXP_MAX);
        to_max   = (rmode_q == RM_RTZ) || ((rmode_q == RM_RDN) && !sign_q) ||
                   ((rmode_q == RM_RUP) && sign_q);
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        rmode_d = rmode_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inx_d   = inx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    rmode_d = in_rmode;
                    exp_d   = (in_exp == '0) ? EXP_ONE : {{(XW-EXP_W){1'b0}}, in_exp};
                    mant_d  = in_mant;
                    if (in_special != SP_NONE) begin
                        state_d = ST_DONE;
                        res_d   = (in_special == SP_INF) ? {in_sign, INF_MAG} : QNAN_W;
                        ovf_d   = 1'b0;
                        unf_d   = 1'b0;
                        inx_d   = 1'b0;
                    end else if (in_mant == '0) begin
                        state_d = ST_DONE;
                        res_d   = {in_sign, {(W-1){1'b0}}};
                        ovf_d   = 1'b0;
                        unf_d   = 1'b0;
                        inx_d   = 1'b0;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (mant_q[MW-1]) begin
                    mant_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + EXP_ONE;
                end else if (!mant_q[MW-2] && (exp_q > EXP_ONE)) begin
                    mant_d = mant_q << shift_k;
                    exp_d  = exp_q - shift_k;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = ST_DONE;
                ovf_d   = rnd_ovf;
                inx_d   = rnd_inexact | rnd_ovf;
                unf_d   = pre_tiny & rnd_inexact;
                if (rnd_ovf) res_d = {sign_q, to_max ? MAXFIN_MAG : INF_MAG};
                else         res_d = {sign_q, exp_fin[EXP_W-1:0], frac_fin};
`ifdef FP_PACK_FTZ_EN
                if (pre_tiny) begin
                    res_d = {sign_q, {(W-1){1'b0}}};
                    unf_d = 1'b1;
                    inx_d = 1'b1;
                    ovf_d = 1'b0;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            rmode_q <= 3'b000;
            exp_q   <= '0;
            mant_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            rmode_q <= rmode_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inx_q   <= inx_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign out_result    = res_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;

endmodule

// File: tb/tb_fp_pack_iter.sv
// tb/tb_fp_pack_iter.sv - directed and random checks of fp_pack_iter against an arithmetic model
module tb_fp_pack_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic [2:0]  in_rmode;
    logic [1:0]  in_special;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_pack_iter #(.EXP_W(8), .MAN_W(23), .SHIFT_STEP(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_rmode      (in_rmode),
        .in_special    (in_special),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Value-level model: shift counts and rounding computed with integer arithmetic.
    function automatic void model(input logic s, input logic [7:0] e_in, input logic [26:0] m_in,
                                  input logic [2:0] rm, input logic [1:0] sp,
                                  output logic [31:0] res, output logic ovf, output logic unf,
                                  output logic inx, output int lat);
        longint m, e, sig, fe, frac, g, st, lsb, inc;
        int     lz, sh, rmx;
        logic   tiny;
        ovf = 1'b0; unf = 1'b0; inx = 1'b0;
        if (sp != 2'b00) begin
            res = (sp == 2'b10) ? {s, 8'hFF, 23'h0} : 32'h7FC0_0000;
            lat = 0;
            return;
        end
        if (m_in == 27'd0) begin
            res = {s, 31'h0};
            lat = 0;
            return;
        end
        m   = longint'(m_in);
        e   = (e_in == 8'd0) ? 1 : longint'(e_in);
        lat = 2;
        if (m >= (64'd1 << 26)) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
            lat = 3;
        end else begin
            lz = 0;
            while ((m << lz) < (64'd1 << 25)) lz++;
            sh = (lz < int'(e - 1)) ? lz : int'(e - 1);
            m   = m << sh;
            e   = e - sh;
            lat = 2 + sh;
        end
        sig  = m >> 2;
        g    = (m >> 1) & 1;
        st   = m & 1;
        lsb  = sig & 1;
        tiny = (sig < (64'd1 << 23));
        inx  = (g | st) != 0;
        rmx  = (rm > 3'd4) ? 0 : int'(rm);
        case (rmx)
            1:       inc = 0;
            2:       inc = (s && inx) ? 1 : 0;
            3:       inc = (!s && inx) ? 1 : 0;
            4:       inc = g;
            default: inc = g & (st | lsb);
        endcase
        sig = sig + inc;
        if (sig >= (64'd1 << 24))      begin fe = e + 1; frac = 0; end
        else if (sig >= (64'd1 << 23)) begin fe = e;     frac = sig - (64'd1 << 23); end
        else                           begin fe = 0;     frac = sig; end
        if (fe >= 255) begin
            ovf = 1'b1;
            inx = 1'b1;
            case (rmx)
                1:       res = {s, 31'h7F7F_FFFF};
                2:       res = s ? {s, 31'h7F80_0000} : {s, 31'h7F7F_FFFF};
                3:       res = s ? {s, 31'h7F7F_FFFF} : {s, 31'h7F80_0000};
                default: res = {s, 31'h7F80_0000};
            endcase
        end else begin
            res = {s, fe[7:0], frac[22:0]};
        end
        unf = tiny & inx;
`ifdef FP_PACK_FTZ_EN
        if (tiny) begin
            res = {s, 31'h0};
            unf = 1'b1;
            inx = 1'b1;
            ovf = 1'b0;
        end
`endif
    endfunction

    task automatic do_op(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                         input logic [2:0] rm, input logic [1:0] sp, input int hold);
        logic [31:0] er;
        logic        eo, eu, ei;
        int          el, n;
        model(s, e, m, rm, sp, er, eo, eu, ei, el);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_rmode = rm; in_special = sp;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin @(negedge clk); n++; end
        chk({tag, ".latency"}, 32'(n), 32'(el));
        chk({tag, ".result"}, out_result, er);
        chk({tag, ".flags"}, {29'd0, out_overflow, out_underflow, out_inexact}, {29'd0, eo, eu, ei});
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk({tag, ".held"}, {out_result}, er);
            chk({tag, ".busy"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".release"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] m;
        logic [1:0]  sp;
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 27'd0;
        in_rmode = 3'd0; in_special = 2'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.outs", {out_result}, 32'h0);
        chk("reset.ctl", {27'd0, out_valid, in_ready, out_overflow, out_underflow, out_inexact},
            {27'd0, 5'b01000});
        rst_n = 1'b1;

        do_op("one",       1'b0, 8'h7F, 27'h200_0000, 3'd0, 2'd0, 0);
        do_op("carry",     1'b0, 8'h7F, 27'h400_0000, 3'd0, 2'd0, 0);
        do_op("rne_up",    1'b0, 8'h7F, 27'h200_0006, 3'd0, 2'd0, 0);
        do_op("rne_tie",   1'b0, 8'h7F, 27'h200_0002, 3'd0, 2'd0, 0);
        do_op("rtz",       1'b0, 8'h7F, 27'h200_0007, 3'd1, 2'd0, 0);
        do_op("rmm",       1'b1, 8'h7F, 27'h200_0002, 3'd4, 2'd0, 0);
        do_op("rsvd_mode", 1'b0, 8'h7F, 27'h200_0006, 3'd6, 2'd0, 0);
        do_op("ovf_rne",   1'b0, 8'hFE, 27'h400_0000, 3'd0, 2'd0, 0);
        do_op("ovf_rtz",   1'b0, 8'hFE, 27'h400_0000, 3'd1, 2'd0, 0);
        do_op("ovf_rdn",   1'b1, 8'hFE, 27'h400_0000, 3'd2, 2'd0, 0);
        do_op("ovf_rup",   1'b1, 8'hFE, 27'h400_0000, 3'd3, 2'd0, 0);
        do_op("subn",      1'b0, 8'h00, 27'h100_0002, 3'd0, 2'd0, 0);
        do_op("norm_long", 1'b0, 8'h40, 27'h000_0010, 3'd0, 2'd0, 0);
        do_op("norm_floor",1'b1, 8'h03, 27'h001_0000, 3'd3, 2'd0, 0);
        do_op("qnan",      1'b1, 8'h12, 27'h123_4567, 3'd0, 2'd1, 0);
        do_op("inf",       1'b1, 8'h12, 27'h123_4567, 3'd0, 2'd2, 0);
        do_op("zero",      1'b1, 8'h55, 27'h000_0000, 3'd0, 2'd0, 0);
        do_op("stall",     1'b0, 8'h80, 27'h2AA_AAAB, 3'd0, 2'd0, 5);

        // Reset while the block is many cycles into normalization.
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_mant = 27'h000_0004;
        in_rmode = 3'd0; in_special = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset.ctl", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
        chk("midreset.res", out_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 1'b0, 8'h7F, 27'h200_0000, 3'd0, 2'd0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       m = {1'b1, 26'($urandom)};
                1:       m = {2'b01, 25'($urandom)};
                default: m = {2'b00, 25'($urandom)} >> $urandom_range(0, 24);
            endcase
            sp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            do_op($sformatf("rnd%0d", i), 1'($urandom), 8'($urandom), m, 3'($urandom_range(0, 7)),
                  sp, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
